// File: rtl/branch_pc_select_if.sv
// Bundle between the EX-stage resolver, the IF-stage fetch mux and the stats bench.
// The pipeline side is the master; branch_pc_select is the slave.
interface branch_pc_select_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic             stall;
   logic [PC_W-1:0]  fetch_pc;
   logic             predict_taken;
   logic             ex_valid;
   logic [1:0]       ex_control;
   logic             ex_taken;
   logic             ex_pred_taken;
   logic [PC_W-1:0]  ex_pc;
   logic [PC_W-1:0]  ex_target;
   logic [1:0]       pc_sel;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             flush;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   // Handshake: an EX instruction is consumed on every rising edge where
   // ex_valid=1 and stall=0; there is no ready back-pressure, stall is the
   // only throttle and upstream holds the EX fields while it is high.
   modport master (
      output stall, fetch_pc, ex_valid, ex_control, ex_taken, ex_pred_taken,
             ex_pc, ex_target,
      input  predict_taken, pc_sel, redirect_valid, redirect_pc, flush,
             branch_cnt, mispredict_cnt
   );

   modport slave (
      input  stall, fetch_pc, ex_valid, ex_control, ex_taken, ex_pred_taken,
             ex_pc, ex_target,
      output predict_taken, pc_sel, redirect_valid, redirect_pc, flush,
             branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_pc_select.sv
// EX-stage branch/jump resolution with registered redirect to fetch, plus a
// direct-mapped table of 2-bit saturating counters predicting at fetch.
module branch_pc_select #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input logic              Clk,
   input logic              Rst_n,
   branch_pc_select_if.slave bus
);
   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       bht [DEPTH];
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       bht_entry;
   logic [1:0]       bht_entry_next;

   logic             resolve;
   logic             is_branch;
   logic             is_jump;
   logic             mispredict;
   logic [PC_W-1:0]  seq_pc;

   logic [1:0]       pc_sel_q;
   logic [1:0]       pc_sel_d;
   logic             redirect_q;
   logic             flush_q;
   logic             redirect_d;
   logic [PC_W-1:0]  redirect_pc_q;
   logic [PC_W-1:0]  redirect_pc_d;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispredict_cnt_q;

   // Only the index bits of each PC feed the table; the rest are don't-care.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.fetch_pc, bus.ex_pc};

   assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
   assign ex_idx    = bus.ex_pc[IDX_W+1:2];

   // Read is from the current array, so a same-cycle update is seen next cycle.
   assign bus.predict_taken = bht[fetch_idx][1];

   assign resolve    = bus.ex_valid & ~bus.stall;
   assign is_branch  = resolve & (bus.ex_control == 2'd1);
   assign is_jump    = resolve & bus.ex_control[1];
   assign mispredict = is_branch & (bus.ex_taken != bus.ex_pred_taken);
   assign seq_pc     = bus.ex_pc + PC_W'(4);

   assign bht_entry = bht[ex_idx];

   always_comb begin
      bht_entry_next = bht_entry;
      if (bus.ex_taken) begin
         if (bht_entry != 2'd3) bht_entry_next = bht_entry + 2'd1;
      end else begin
         if (bht_entry != 2'd0) bht_entry_next = bht_entry - 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
      end else if (is_branch) begin
         bht[ex_idx] <= bht_entry_next;
      end
   end

   // Comparator-low on a branch forces the sequential source (legacy rule).
   always_comb begin
      pc_sel_d      = pc_sel_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (resolve) begin
         if (bus.ex_control == 2'd1 && !bus.ex_taken) pc_sel_d = 2'd0;
         else                                          pc_sel_d = bus.ex_control;
      end
      if (mispredict) begin
         redirect_d    = 1'b1;
         redirect_pc_d = bus.ex_taken ? bus.ex_target : seq_pc;
      end else if (is_jump) begin
         redirect_d    = 1'b1;
         redirect_pc_d = bus.ex_target;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pc_sel_q      <= 2'd0;
         redirect_q    <= 1'b0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         pc_sel_q      <= pc_sel_d;
         redirect_q    <= redirect_d;
         flush_q       <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Statistics stick at all-ones rather than wrapping.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (is_branch && branch_cnt_q != '1)
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if (mispredict && mispredict_cnt_q != '1)
            mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
   end

   assign bus.pc_sel         = pc_sel_q;
   assign bus.redirect_valid = redirect_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flush          = flush_q;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_pc_select.sv
// Bench for branch_pc_select: directed scenarios then random traffic, checked
// against an abstract model; a second instance with 2-bit counters shares stimulus.
module tb_branch_pc_select;
   logic Clk;
   logic Rst_n;

   logic        drv_stall;
   logic [31:0] drv_fetch_pc;
   logic        drv_valid;
   logic [1:0]  drv_control;
   logic        drv_taken;
   logic        drv_pred;
   logic [31:0] drv_pc;
   logic [31:0] drv_target;

   branch_pc_select_if #(.PC_W(32), .CNT_W(16)) bus ();
   branch_pc_select_if #(.PC_W(32), .CNT_W(2))  bus_s ();

   assign bus.stall           = drv_stall;
   assign bus.fetch_pc        = drv_fetch_pc;
   assign bus.ex_valid        = drv_valid;
   assign bus.ex_control      = drv_control;
   assign bus.ex_taken        = drv_taken;
   assign bus.ex_pred_taken   = drv_pred;
   assign bus.ex_pc           = drv_pc;
   assign bus.ex_target       = drv_target;
   assign bus_s.stall         = drv_stall;
   assign bus_s.fetch_pc      = drv_fetch_pc;
   assign bus_s.ex_valid      = drv_valid;
   assign bus_s.ex_control    = drv_control;
   assign bus_s.ex_taken      = drv_taken;
   assign bus_s.ex_pred_taken = drv_pred;
   assign bus_s.ex_pc         = drv_pc;
   assign bus_s.ex_target     = drv_target;

   branch_pc_select #(.PC_W(32), .IDX_W(6), .CNT_W(16)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
   );
   branch_pc_select #(.PC_W(32), .IDX_W(6), .CNT_W(2)) dut_s (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus_s)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Reference state: counter strengths 0..3 per table slot, unbounded event counts.
   int          m_bht [64];
   int          m_pc_sel;
   bit          m_redirect;
   logic [31:0] m_rpc;
   int          m_bc;
   int          m_mc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic bit model_pred(input logic [31:0] pc);
      return m_bht[slot(pc)] >= 2;
   endfunction

   function automatic int clamp(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_pc_sel = 0; m_redirect = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
   endtask

   task automatic model_step();
      longint wrapped;
      m_redirect = 0;
      if (drv_valid && !drv_stall) begin
         m_pc_sel = (drv_control == 1 && !drv_taken) ? 0 : int'(drv_control);
         if (drv_control == 1) begin
            if (drv_taken) m_bht[slot(drv_pc)] = clamp(m_bht[slot(drv_pc)] + 1, 3);
            else if (m_bht[slot(drv_pc)] > 0) m_bht[slot(drv_pc)]--;
            m_bc++;
            if (drv_taken != drv_pred) begin
               m_redirect = 1;
               wrapped = (longint'(drv_pc) + 4) % 64'h1_0000_0000;
               m_rpc = drv_taken ? drv_target : wrapped[31:0];
               m_mc++;
            end
         end else if (drv_control >= 2) begin
            m_redirect = 1;
            m_rpc = drv_target;
         end
      end
   endtask

   task automatic check_outputs();
      check("pc_sel",          bus.pc_sel,           m_pc_sel[1:0]);
      check("redirect_valid",  bus.redirect_valid,   m_redirect);
      check("flush",           bus.flush,            m_redirect);
      check("redirect_pc",     bus.redirect_pc,      m_rpc);
      check("branch_cnt",      bus.branch_cnt,       clamp(m_bc, 65535));
      check("mispredict_cnt",  bus.mispredict_cnt,   clamp(m_mc, 65535));
      check("branch_cnt_s",    bus_s.branch_cnt,     clamp(m_bc, 3));
      check("mispredict_cnt_s",bus_s.mispredict_cnt, clamp(m_mc, 3));
      check("flush_s",         bus_s.flush,          m_redirect);
   endtask

   // Drive one EX slot plus a fetch PC and advance one clock.
   task automatic cyc(input bit v, input logic [1:0] c, input bit t, input bit p,
                      input logic [31:0] pc, input logic [31:0] tgt, input bit st,
                      input logic [31:0] fpc);
      drv_valid = v; drv_control = c; drv_taken = t; drv_pred = p;
      drv_pc = pc; drv_target = tgt; drv_stall = st; drv_fetch_pc = fpc;
      #2;
      check("predict_pre", bus.predict_taken, model_pred(drv_fetch_pc));
      check("predict_pre_s", bus_s.predict_taken, model_pred(drv_fetch_pc));
      model_step();
      @(posedge Clk);
      #1;
      check_outputs();
      check("predict_post", bus.predict_taken, model_pred(drv_fetch_pc));
   endtask

   task automatic idle(input logic [31:0] fpc);
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fpc);
   endtask

   // Assert reset between edges; outputs must clear without waiting for a clock.
   task automatic do_reset();
      @(negedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_pc_sel",     bus.pc_sel,         2'd0);
      check("rst_redirect",   bus.redirect_valid, 1'b0);
      check("rst_flush",      bus.flush,          1'b0);
      check("rst_rpc",        bus.redirect_pc,    32'h0);
      check("rst_branch_cnt", bus.branch_cnt,     16'h0);
      check("rst_mis_cnt",    bus.mispredict_cnt, 16'h0);
      check("rst_mis_cnt_s",  bus_s.mispredict_cnt, 2'd0);
      for (int i = 0; i < 64; i++) begin
         drv_fetch_pc = ($urandom & 32'hFFFF_FF00) | (32'(i) * 4);
         #1;
         check("rst_predict", bus.predict_taken, 1'b0);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   initial begin
      int snap_bc, snap_mc;
      logic [31:0] rpc, fpc;
      Rst_n = 1'b0;
      drv_stall = 0; drv_fetch_pc = 0; drv_valid = 0; drv_control = 0;
      drv_taken = 0; drv_pred = 0; drv_pc = 0; drv_target = 0;
      model_reset();
      do_reset();

      // Training: two taken resolves at 0x40 both predicted not-taken.
      cyc(1, 2'd1, 1, 0, 32'h40, 32'h100, 0, 32'h40);
      check("train1_flush", bus.flush, 1'b1);
      check("train1_rpc", bus.redirect_pc, 32'h100);
      cyc(1, 2'd1, 1, 0, 32'h40, 32'h100, 0, 32'h40);
      idle(32'h40);
      check("train_pred", bus.predict_taken, 1'b1);
      check("train_mc", bus.mispredict_cnt, 16'd2);
      check("train_bc", bus.branch_cnt, 16'd2);

      // Not-taken recovery at the top of the address space wraps to 0.
      cyc(1, 2'd1, 0, 1, 32'hFFFF_FFFC, 32'h1234, 0, 32'h0);
      check("wrap_pc_sel", bus.pc_sel, 2'd0);
      check("wrap_rpc", bus.redirect_pc, 32'h0);
      check("wrap_flush", bus.flush, 1'b1);
      idle(32'h0);
      check("wrap_flush_drop", bus.flush, 1'b0);

      // Jump-register leaves table and counters alone.
      snap_bc = m_bc; snap_mc = m_mc;
      cyc(1, 2'd3, 0, 0, 32'h500, 32'h2000, 0, 32'h500);
      check("jr_pc_sel", bus.pc_sel, 2'd3);
      check("jr_rpc", bus.redirect_pc, 32'h2000);
      check("jr_flush", bus.flush, 1'b1);
      check("jr_bc", bus.branch_cnt, 16'(snap_bc));
      check("jr_mc", bus.mispredict_cnt, 16'(snap_mc));

      // Mispredict held under stall for three cycles.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 2'd1, 1, 0, 32'h80, 32'h300, 1, 32'h80);
         check("stall_flush", bus.flush, 1'b0);
      end
      cyc(1, 2'd1, 1, 0, 32'h80, 32'h300, 0, 32'h80);
      check("stall_release_flush", bus.flush, 1'b1);
      check("stall_release_rpc", bus.redirect_pc, 32'h300);
      idle(32'h80);
      check("stall_pulse_end", bus.flush, 1'b0);

      // Fifth mispredict, same-index fetch: old value before edge, new after.
      cyc(1, 2'd1, 0, 1, 32'h80, 32'h0, 0, 32'h80);
      check("sat_mc_s", bus_s.mispredict_cnt, 2'd3);
      check("sat_mc", bus.mispredict_cnt, 16'd5);

      // Reset while a redirect is on the outputs.
      cyc(1, 2'd2, 0, 0, 32'h600, 32'h4000, 0, 32'h0);
      check("pre_reset_flush", bus.flush, 1'b1);
      do_reset();

      for (int n = 0; n < 800; n++) begin
         drv_pc = $urandom & 32'hFFFF_FFFC;
         rpc = $urandom & 32'hFFFF_FFFC;
         fpc = ($urandom_range(0, 3) == 0) ? drv_pc : ($urandom & 32'hFFFF_FFFC);
         cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? model_pred(drv_pc) : 1'($urandom_range(0, 1)),
             drv_pc, rpc, $urandom_range(0, 4) == 0, fpc);
         if (n == 400) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_pc_select.md
# branch_pc_select

Parametrised successor to the two-bit PC-source selector: resolves branches and jumps in EX, drives the registered PC-source code and redirect address to the fetch mux, and predicts conditional branches at fetch from a direct-mapped table of 2-bit saturating counters. It sits between the EX-stage comparator/control decode and the IF-stage PC register. Mispredictions raise a one-cycle flush. Saturating statistics counters are provided for the performance bench.

## Interface
Parameters:
- PC_W, 32, PC and target width
- IDX_W, 6, BHT index width; DEPTH = 2**IDX_W entries
- CNT_W, 16, width of statistics counters

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; EX inputs ignored while high
- fetch_pc  in  PC_W  current IF PC
- predict_taken  out  1  combinational prediction for fetch_pc
- ex_valid  in  1  EX slot holds a real instruction
- ex_control  in  2  control PC-source: 0 seq, 1 branch, 2 jump, 3 jump-register
- ex_taken  in  1  comparator result (branch condition true)
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_target  in  PC_W  branch/jump/jr target
- pc_sel  out  2  registered PC-source code
- redirect_valid  out  1  registered; fetch must load redirect_pc
- redirect_pc  out  PC_W  registered redirect address
- flush  out  1  registered; kill IF/ID
- branch_cnt  out  CNT_W  resolved conditional branches
- mispredict_cnt  out  CNT_W  mispredicted conditional branches

## Operation
- Index: idx(pc) = pc[IDX_W+1:2].
- BHT: DEPTH x 2-bit counters; predict_taken = bht[idx(fetch_pc)][1].
- Resolve event R = ex_valid & ~stall.
- On R, next pc_sel:
  - 0 if ex_control==1 and ex_taken==0;
  - otherwise ex_control.
  - This is the legacy rule: comparator low forces 0.
- Branch (R, ex_control==1):
  - Update bht[idx(ex_pc)]: ex_taken increments, saturating at 3; else decrements, saturating at 0.
  - Increment branch_cnt.
  - Mispredict if ex_taken != ex_pred_taken. On mispredict:
    - redirect_valid=1 and flush=1;
    - redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2**PC_W);
    - increment mispredict_cnt.
- Jump (R, ex_control 2 or 3): redirect_valid=1, flush=1, redirect_pc=ex_target. No BHT or counter change.
- ex_control==0, or no R:
  - redirect_valid=0 and flush=0 next cycle;
  - redirect_pc holds its value;
  - pc_sel: becomes 0 on an R cycle; holds on ~R cycles.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (Rst_n low, asynchronous):
  - all BHT entries 2'b01 (weakly not-taken);
  - pc_sel=0, redirect_valid=0, redirect_pc=0, flush=0, branch_cnt=0, mispredict_cnt=0.
  - Reset mid-operation aborts any pending redirect immediately.
- predict_taken: zero latency, combinational from fetch_pc and the current BHT state.
- Same-index read/write in one cycle: predict_taken returns the pre-update value. The update becomes visible the next cycle.
- Resolution outputs (pc_sel, redirect_valid, redirect_pc, flush): registered, one-cycle latency after the R cycle.
- redirect_valid and flush:
  - single-cycle pulses;
  - back-to-back redirects on consecutive R cycles are each reported;
  - the younger instruction wins nothing: upstream guarantees a flushed slot has ex_valid=0.
- stall high: no BHT update, no counter change, no new redirect. Registered outputs clear flush and redirect_valid and hold pc_sel. Upstream holds the EX inputs until stall drops.
- First clock edge after Rst_n rises: normal operation.

## Test plan
- Reset: drive Rst_n=0 mid-run -> all outputs 0 immediately; predict_taken=0 for every fetch_pc.
- Training: branch at ex_pc=0x40 resolved taken twice, ex_pred_taken=0 both times, ex_target=0x100:
  - first resolve -> counter 01→10, flush and redirect_pc=0x100;
  - second resolve -> counter 10→11;
  - fetch_pc=0x40 -> predict_taken=1;
  - mispredict_cnt=2, branch_cnt=2.
- Not-taken recovery: ex_pred_taken=1, ex_taken=0, ex_pc=0xFFFFFFFC -> pc_sel=0, redirect_pc=0x00000000 (wrap), flush pulse one cycle.
- Jump-register: ex_control=3, ex_target=0x2000 -> pc_sel=3, redirect_pc=0x2000, flush=1; BHT and counters unchanged.
- Stall: branch mispredict presented with stall=1 for 3 cycles, then stall=0:
  - no flush and no update during the stall;
  - single flush one cycle after stall drops.
- Saturation: CNT_W=2, 5 mispredicts -> mispredict_cnt stays at 3. Same-index fetch/update in one cycle -> predict_taken shows the old counter value.
